tank_ctrl: RTL and testbench

- Per-player tank state writer. Converts one joystick's raw button levels into the tank position and heading that the VGA renderer reads (i_tankN_x / i_tankN_y / i_tankN_dir), plus a fire-request pulse.
- Runs in the 25 MHz VGA clock domain.
- Commits position and heading only while the renderer is not busy, using the same i_VGA_buzy interlock as the timer.
- One instance per player.

---
 rtl/tank_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_tank_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/tank_ctrl.sv
// Per-player tank state writer: turns raw joystick levels into the tile
// position, heading and fire pulse read by the VGA renderer. Position and
// heading only change while the renderer is not sampling them (i_VGA_buzy=0).
module tank_ctrl #(
    parameter int INIT_X        = 2,
    parameter int INIT_Y        = 2,
    parameter int INIT_DIR      = 0,
    parameter int X_MAX         = 39,
    parameter int Y_MAX         = 29,
    parameter int MOVE_PERIOD   = 2500000,
    parameter int FIRE_COOLDOWN = 12500000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] i_top_state,
    input  logic       i_VGA_buzy,
    input  logic       i_up,
    input  logic       i_down,
    input  logic       i_left,
    input  logic       i_right,
    input  logic       i_fire,
    output logic [5:0] o_x,
    output logic [5:0] o_y,
    output logic [1:0] o_dir,
    output logic       o_fire,
    output logic [4:0] o_led
);

    localparam int MCW = (MOVE_PERIOD > 2) ? $clog2(MOVE_PERIOD) : 1;
    localparam int FCW = $clog2(FIRE_COOLDOWN + 1);

    localparam logic [5:0]     C_INIT_X = 6'(INIT_X);
    localparam logic [5:0]     C_INIT_Y = 6'(INIT_Y);
    localparam logic [1:0]     C_INIT_D = 2'(INIT_DIR);
    localparam logic [5:0]     C_X_MAX  = 6'(X_MAX);
    localparam logic [5:0]     C_Y_MAX  = 6'(Y_MAX);
    // The counter is compared before its increment, so the step fires on the
    // cycle the count rolls into MOVE_PERIOD-1; commit then lands one period
    // after the previous commit.
    localparam logic [MCW-1:0] C_MV_LAST = MCW'(MOVE_PERIOD - 2);
    localparam logic [FCW-1:0] C_CD_LOAD = FCW'(FIRE_COOLDOWN - 1);

    localparam logic [1:0] D_UP    = 2'd0;
    localparam logic [1:0] D_RIGHT = 2'd1;
    localparam logic [1:0] D_DOWN  = 2'd2;
    localparam logic [1:0] D_LEFT  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_READY,
        S_HOLD,
        S_COMMIT
    } state_t;

    state_t         r_state;
    logic [4:0]     r_btn_s1;
    logic [4:0]     r_btn_s2;
    logic           r_fire_d;
    logic [1:0]     r_pend;
    logic [MCW-1:0] r_mcnt;
    logic [FCW-1:0] r_cd;

    logic [4:0]     w_btn_raw;
    logic           w_req_vld;
    logic [1:0]     w_req_dir;
    logic           w_fire_rise;
    logic           w_play;

    assign w_btn_raw   = {i_fire, i_right, i_left, i_down, i_up};
    assign w_fire_rise = r_btn_s2[4] & ~r_fire_d;
    assign w_play      = (i_top_state == 2'b01);
    assign o_led       = r_btn_s2;

    // Two-flop synchronizer for every button, plus the fire edge register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_btn_s1 <= '0;
            r_btn_s2 <= '0;
            r_fire_d <= 1'b0;
        end else begin
            r_btn_s1 <= w_btn_raw;
            r_btn_s2 <= r_btn_s1;
            r_fire_d <= r_btn_s2[4];
        end
    end

    // Requested direction with up > down > left > right priority.
    always_comb begin
        w_req_vld = 1'b1;
        w_req_dir = D_UP;
        if (r_btn_s2[0])      w_req_dir = D_UP;
        else if (r_btn_s2[1]) w_req_dir = D_DOWN;
        else if (r_btn_s2[2]) w_req_dir = D_LEFT;
        else if (r_btn_s2[3]) w_req_dir = D_RIGHT;
        else                  w_req_vld = 1'b0;
    end

    // Movement FSM: latch requests, pace steps, commit only when not buzy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_pend  <= C_INIT_D;
            r_mcnt  <= '0;
            o_x     <= C_INIT_X;
            o_y     <= C_INIT_Y;
            o_dir   <= C_INIT_D;
        end else if (i_top_state == 2'b00) begin
            // Reinit from any state; a pending commit is thrown away.
            r_state <= S_IDLE;
            r_pend  <= C_INIT_D;
            r_mcnt  <= '0;
            o_x     <= C_INIT_X;
            o_y     <= C_INIT_Y;
            o_dir   <= C_INIT_D;
        end else if (i_top_state[1]) begin
            // Paused: everything holds, including any pending commit.
            r_state <= r_state;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_mcnt  <= '0;
                    o_x     <= C_INIT_X;
                    o_y     <= C_INIT_Y;
                    o_dir   <= C_INIT_D;
                    r_state <= S_READY;
                end
                S_READY: begin
                    if (w_req_vld) begin
                        r_pend  <= w_req_dir;
                        r_state <= S_COMMIT;
                    end
                end
                S_HOLD: begin
                    if (!w_req_vld) begin
                        r_mcnt  <= '0;
                        r_state <= S_READY;
                    end else if (w_req_dir != r_pend) begin
                        r_pend  <= w_req_dir;
                        r_mcnt  <= '0;
                        r_state <= S_COMMIT;
                    end else begin
                        r_mcnt <= r_mcnt + 1'b1;
                        if (r_mcnt == C_MV_LAST) r_state <= S_COMMIT;
                    end
                end
                S_COMMIT: begin
                    if (!i_VGA_buzy) begin
                        r_mcnt  <= '0;
                        r_state <= S_HOLD;
                        if (r_pend != o_dir) begin
                            o_dir <= r_pend;
                        end else begin
                            // Step, dropped if it would leave the playfield.
                            case (r_pend)
                                D_UP:    if (o_y != 6'd0)  o_y <= o_y - 6'd1;
                                D_RIGHT: if (o_x < C_X_MAX) o_x <= o_x + 6'd1;
                                D_DOWN:  if (o_y < C_Y_MAX) o_y <= o_y + 6'd1;
                                default: if (o_x != 6'd0)  o_x <= o_x - 6'd1;
                            endcase
                        end
                    end else if (w_req_vld && (w_req_dir != r_pend)) begin
                        // New direction while waiting replaces the pending action.
                        r_pend <= w_req_dir;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Fire pulse with cooldown; the cooldown keeps running in every top state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_fire <= 1'b0;
            r_cd   <= '0;
        end else if (w_fire_rise && w_play && (r_cd == '0)) begin
            o_fire <= 1'b1;
            r_cd   <= C_CD_LOAD;
        end else begin
            o_fire <= 1'b0;
            if (r_cd != '0) r_cd <= r_cd - 1'b1;
        end
    end

endmodule

// File: tb/tb_tank_ctrl.sv
// Directed bench for tank_ctrl with short move period and fire cooldown.
module tb_tank_ctrl;

    logic       clk;
    logic       rst_n;
    logic [1:0] top;
    logic       buzy;
    logic       up, down, left, right, fire;
    logic [5:0] x, y;
    logic [1:0] dir;
    logic       fire_o;
    logic [4:0] led;

    int n_vec = 0;
    int n_err = 0;

    tank_ctrl #(
        .INIT_X(2), .INIT_Y(2), .INIT_DIR(0), .X_MAX(39), .Y_MAX(29),
        .MOVE_PERIOD(4), .FIRE_COOLDOWN(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_top_state(top), .i_VGA_buzy(buzy),
        .i_up(up), .i_down(down), .i_left(left), .i_right(right), .i_fire(fire),
        .o_x(x), .o_y(y), .o_dir(dir), .o_fire(fire_o), .o_led(led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic tickn(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b1; top = 2'b01; buzy = 1'b0;
        up = 1'b0; down = 1'b0; left = 1'b0; right = 1'b0; fire = 1'b0;
        #2 rst_n = 1'b0;
        tickn(2);
        chk("rst_x", x, 2);
        chk("rst_y", y, 2);
        chk("rst_dir", dir, 0);
        chk("rst_fire", fire_o, 0);
        chk("rst_led", led, 0);
        rst_n = 1'b1;
        tickn(2);

        // Right press: turn after 4 cycles, then a step every 4 cycles.
        right = 1'b1;
        tickn(3);
        chk("turn_early_dir", dir, 0);
        tick();
        chk("turn_dir", dir, 1);
        chk("turn_x", x, 2);
        chk("led_right", led, 5'b01000);
        tickn(3);
        chk("pre_step_x", x, 2);
        tick();
        chk("step1_x", x, 3);
        tickn(4);
        chk("step2_x", x, 4);
        right = 1'b0;
        tickn(6);

        // Up to the top edge, then hold: no wrap below 0.
        up = 1'b1;
        tickn(4);
        chk("up_turn_dir", dir, 0);
        chk("up_turn_y", y, 2);
        tickn(4);
        chk("up_y1", y, 1);
        tickn(4);
        chk("up_y0", y, 0);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("y_clamp", y, 0);
        end
        chk("up_x", x, 4);
        up = 1'b0;
        tickn(6);

        // Right again, with a buzy window covering the step due at cycle 16.
        right = 1'b1;
        tickn(4);
        chk("r2_dir", dir, 1);
        chk("r2_x", x, 4);
        tickn(4);
        chk("r2_x5", x, 5);
        tickn(4);
        chk("r2_x6", x, 6);
        tick();
        buzy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("buzy_hold_x", x, 6);
        end
        buzy = 1'b0;
        tick();
        chk("buzy_release_x", x, 7);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("one_step_x", x, 7);
        end
        tick();
        chk("post_buzy_x", x, 8);
        tickn(124);
        chk("reach_xmax", x, 39);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("x_clamp", x, 39);
        end
        right = 1'b0;
        tickn(6);

        // Fire presses at cycles 0, 3 and 12 (each held two cycles).
        fire = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            tick();
            chk($sformatf("fire_c%0d", c), fire_o, (c == 3 || c == 15) ? 1 : 0);
            fire = (c == 1 || c == 3 || c == 4 || c == 12 || c == 13);
        end
        fire = 1'b0;

        // Reinit, move to x=5, pause, then reinit from pause.
        top = 2'b00;
        tick();
        chk("reinit_x", x, 2);
        chk("reinit_y", y, 2);
        chk("reinit_dir", dir, 0);
        top = 2'b01;
        tick();
        right = 1'b1;
        tickn(16);
        chk("pre_pause_x", x, 5);
        top = 2'b10;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("pause_x", x, 5);
            chk("pause_dir", dir, 1);
        end
        top = 2'b00;
        tick();
        chk("idle_x", x, 2);
        chk("idle_y", y, 2);
        chk("idle_dir", dir, 0);
        right = 1'b0;
        tickn(3);

        // Up+left: up wins; releasing up turns left four cycles later.
        top = 2'b01;
        tick();
        up = 1'b1;
        left = 1'b1;
        tickn(4);
        chk("prio_dir", dir, 0);
        chk("prio_y", y, 1);
        chk("prio_x", x, 2);
        chk("led_up_left", led, 5'b00101);
        up = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("left_wait_dir", dir, 0);
        end
        tick();
        chk("left_dir", dir, 3);
        chk("left_x", x, 2);
        chk("left_y", y, 1);
        left = 1'b0;
        tickn(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
